// File: rtl/lpif_txrx_x8_half_tx_sched.sv
// Half-rate LPIF TX sequencer: pairs single-lane beats into TX FIFO words (gen2) or passes one beat per word (gen1).
// Optional statistics counters are enabled with `define LPIF_TXSCHED_STATS_EN.
module lpif_txrx_x8_half_tx_sched #(
  parameter int LANE_W = 273,
  parameter int WORD_W = 546,
  parameter int CNT_W  = 16
) (
  input  logic              clk_wr,
  input  logic              rst_wr_n,
  input  logic              m_gen2_mode,
  input  logic              beat_vld,
  output logic              beat_rdy,
  input  logic [3:0]        beat_state,
  input  logic [1:0]        beat_protid,
  input  logic [255:0]      beat_data,
  input  logic              beat_dvalid,
  input  logic [7:0]        beat_crc,
  input  logic              beat_crc_valid,
  input  logic              beat_valid,
  input  logic              flush,
  input  logic              txfifo_full,
  output logic              txfifo_push,
  output logic [WORD_W-1:0] txfifo_downstream_data,
  output logic              half_pending,
  output logic [CNT_W-1:0]  stat_words,
  output logic [CNT_W-1:0]  stat_stalls
);

  typedef enum logic {EMPTY, HALF} state_t;

  state_t              state;
  logic [LANE_W-1:0]   beat;
  logic [LANE_W-1:0]   hold;
  logic                out_vld;
  logic [WORD_W-1:0]   out_word;
  logic                rdy_en;
  logic                stage_free;
  logic                accept;

  assign beat = {beat_valid, beat_crc_valid, beat_crc, beat_dvalid,
                 beat_data, beat_protid, beat_state};

  assign stage_free  = !out_vld || !txfifo_full;
  // A gen2 beat in EMPTY only needs the hold register, so it never waits on the FIFO.
  assign beat_rdy    = rdy_en && ((state == EMPTY && m_gen2_mode) || stage_free);
  assign accept      = beat_vld && beat_rdy;
  assign txfifo_push = out_vld && !txfifo_full;
  assign txfifo_downstream_data = out_word;
  assign half_pending = (state == HALF);

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state    <= EMPTY;
      hold     <= '0;
      out_vld  <= 1'b0;
      out_word <= '0;
      rdy_en   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (txfifo_push) out_vld <= 1'b0;
      unique case (state)
        EMPTY: begin
          if (accept) begin
            if (m_gen2_mode) begin
              hold  <= beat;
              state <= HALF;
            end else begin
              out_vld  <= 1'b1;
              out_word <= {{(WORD_W-LANE_W){1'b0}}, beat};
            end
          end
        end
        HALF: begin
          if (accept) begin
            out_vld  <= 1'b1;
            out_word <= {beat, hold};
            state    <= EMPTY;
          end else if (flush && stage_free) begin
            out_vld  <= 1'b1;
            out_word <= {{(WORD_W-LANE_W){1'b0}}, hold};
            state    <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef LPIF_TXSCHED_STATS_EN
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (txfifo_push && stat_words != '1) stat_words <= stat_words + 1'b1;
      if (beat_vld && !beat_rdy && stat_stalls != '1) stat_stalls <= stat_stalls + 1'b1;
    end
  end
`else
  assign stat_words  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_lpif_txrx_x8_half_tx_sched.sv
// Directed table-driven bench for the half-rate TX scheduler, plus a mid-operation reset sequence.
module tb_lpif_txrx_x8_half_tx_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         gen2 = 1'b0;
  logic         vld = 1'b0;
  logic         rdy;
  logic [3:0]   b_state = '0;
  logic [1:0]   b_protid = '0;
  logic [255:0] b_data = '0;
  logic         b_dvalid = 1'b0;
  logic [7:0]   b_crc = '0;
  logic         b_crc_valid = 1'b0;
  logic         b_valid = 1'b0;
  logic         flush = 1'b0;
  logic         full = 1'b0;
  logic         push;
  logic [545:0] word;
  logic         half;
  logic [15:0]  st_words;
  logic [15:0]  st_stalls;

  int unsigned tests = 0;
  int unsigned fails = 0;

  lpif_txrx_x8_half_tx_sched #(.LANE_W(273), .WORD_W(546), .CNT_W(16)) dut (
    .clk_wr(clk), .rst_wr_n(rst_n), .m_gen2_mode(gen2),
    .beat_vld(vld), .beat_rdy(rdy),
    .beat_state(b_state), .beat_protid(b_protid), .beat_data(b_data),
    .beat_dvalid(b_dvalid), .beat_crc(b_crc), .beat_crc_valid(b_crc_valid),
    .beat_valid(b_valid), .flush(flush), .txfifo_full(full),
    .txfifo_push(push), .txfifo_downstream_data(word),
    .half_pending(half), .stat_words(st_words), .stat_stalls(st_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       gen2, vld;
    logic [7:0] tag;
    logic       flush, full;
    logic       rdy, push, half;
    logic [7:0] lo, hi;
  } vec_t;

  vec_t vq[$];

  // Tag 0 stands for an all-zero lane.
  function automatic logic [272:0] lane(input logic [7:0] t);
    if (t == 8'h00) return '0;
    return {1'b1, 1'b1, t, 1'b1, {32{t}}, t[5:4], t[3:0]};
  endfunction

  task automatic add(input logic g, input logic v, input logic [7:0] t, input logic f,
                     input logic fl, input logic r, input logic p, input logic h,
                     input logic [7:0] lo, input logic [7:0] hi);
    vec_t e;
    e.gen2 = g; e.vld = v; e.tag = t; e.flush = f; e.full = fl;
    e.rdy = r; e.push = p; e.half = h; e.lo = lo; e.hi = hi;
    vq.push_back(e);
  endtask

  task automatic drive(input logic g, input logic v, input logic [7:0] t,
                       input logic f, input logic fl);
    gen2 = g; vld = v; flush = f; full = fl;
    b_state = t[3:0]; b_protid = t[5:4]; b_data = {32{t}}; b_dvalid = 1'b1;
    b_crc = t; b_crc_valid = 1'b1; b_valid = 1'b1;
  endtask

  task automatic chk(input string name, input logic [545:0] act, input logic [545:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int unsigned exp_words = 0;
  int unsigned exp_stalls = 0;

  initial begin
    // gen2 pair 11/22
    add(1,1,8'h11,0,0, 1,0,0, 8'h00,8'h00);
    add(1,1,8'h22,0,0, 1,0,1, 8'h00,8'h00);
    add(1,0,8'h00,0,0, 1,1,0, 8'h11,8'h22);
    // gen1 three beats
    add(0,1,8'h33,0,0, 1,0,0, 8'h11,8'h22);
    add(0,1,8'h44,0,0, 1,1,0, 8'h33,8'h00);
    add(0,1,8'h55,0,0, 1,1,0, 8'h44,8'h00);
    add(0,0,8'h00,0,0, 1,1,0, 8'h55,8'h00);
    // gen2 single beat then flush
    add(1,1,8'h66,0,0, 1,0,0, 8'h55,8'h00);
    add(1,0,8'h00,1,0, 1,0,1, 8'h55,8'h00);
    add(1,0,8'h00,0,0, 1,1,0, 8'h66,8'h00);
    // beat and flush together in HALF, then flush in EMPTY
    add(1,1,8'h77,0,0, 1,0,0, 8'h66,8'h00);
    add(1,1,8'h88,1,0, 1,0,1, 8'h66,8'h00);
    add(1,0,8'h00,0,0, 1,1,0, 8'h77,8'h88);
    add(1,0,8'h00,1,0, 1,0,0, 8'h77,8'h88);
    add(1,0,8'h00,0,0, 1,0,0, 8'h77,8'h88);
    // back-pressure: full for five cycles with a word pending
    add(1,1,8'h99,0,0, 1,0,0, 8'h77,8'h88);
    add(1,1,8'hAA,0,1, 1,0,1, 8'h77,8'h88);
    add(1,1,8'hBB,0,1, 1,0,0, 8'h99,8'hAA);
    add(1,1,8'hCC,0,1, 0,0,1, 8'h99,8'hAA);
    add(1,1,8'hCC,0,1, 0,0,1, 8'h99,8'hAA);
    add(1,1,8'hCC,0,1, 0,0,1, 8'h99,8'hAA);
    add(1,1,8'hCC,0,0, 1,1,1, 8'h99,8'hAA);
    add(1,0,8'h00,0,0, 1,1,0, 8'hBB,8'hCC);
    // gen2 -> gen1 change while HALF
    add(1,1,8'hDD,0,0, 1,0,0, 8'hBB,8'hCC);
    add(0,1,8'hEE,0,0, 1,0,1, 8'hBB,8'hCC);
    add(0,1,8'h12,0,0, 1,1,0, 8'hDD,8'hEE);
    add(0,0,8'h00,0,0, 1,1,0, 8'h12,8'h00);
    add(0,0,8'h00,0,0, 1,0,0, 8'h12,8'h00);

    // Reset state
    #2;
    chk("reset_rdy", 546'(rdy), 546'(0));
    chk("reset_push", 546'(push), 546'(0));
    chk("reset_half", 546'(half), 546'(0));
    chk("reset_data", word, '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].gen2, vq[i].vld, vq[i].tag, vq[i].flush, vq[i].full);
      #4;
      chk($sformatf("v%0d_rdy", i), 546'(rdy), 546'(vq[i].rdy));
      chk($sformatf("v%0d_push", i), 546'(push), 546'(vq[i].push));
      chk($sformatf("v%0d_half", i), 546'(half), 546'(vq[i].half));
      chk($sformatf("v%0d_data", i), word, {lane(vq[i].hi), lane(vq[i].lo)});
      if (vq[i].push) exp_words++;
      if (vq[i].vld && !vq[i].rdy) exp_stalls++;
    end
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 0);
    #4;
`ifdef LPIF_TXSCHED_STATS_EN
    chk("stat_words", 546'(st_words), 546'(exp_words));
    chk("stat_stalls", 546'(st_stalls), 546'(exp_stalls));
`else
    chk("stat_words_off", 546'(st_words), 546'(0));
    chk("stat_stalls_off", 546'(st_stalls), 546'(0));
`endif

    // Reset while HALF with the output stage loaded
    @(negedge clk); drive(1, 1, 8'h31, 0, 0);
    @(negedge clk); drive(1, 1, 8'h32, 0, 1);
    @(negedge clk); drive(1, 1, 8'h33, 0, 1);
    @(negedge clk); drive(1, 0, 8'h00, 0, 0);
    #1;
    chk("pre_rst_push", 546'(push), 546'(1));
    chk("pre_rst_half", 546'(half), 546'(1));
    chk("pre_rst_data", word, {lane(8'h32), lane(8'h31)});
    rst_n = 1'b0;
    #1;
    chk("rst_push", 546'(push), 546'(0));
    chk("rst_half", 546'(half), 546'(0));
    chk("rst_rdy", 546'(rdy), 546'(0));
    chk("rst_data", word, '0);
    chk("rst_words", 546'(st_words), 546'(0));
    chk("rst_stalls", 546'(st_stalls), 546'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk); drive(1, 1, 8'h41, 0, 0);
    #4;
    chk("post_rst_rdy", 546'(rdy), 546'(1));
    chk("post_rst_half0", 546'(half), 546'(0));
    chk("post_rst_nopush", 546'(push), 546'(0));
    @(negedge clk); drive(1, 1, 8'h42, 0, 0);
    #4;
    chk("post_rst_half1", 546'(half), 546'(1));
    @(negedge clk); drive(1, 0, 8'h00, 0, 0);
    #4;
    chk("post_rst_push", 546'(push), 546'(1));
    chk("post_rst_data", word, {lane(8'h42), lane(8'h41)});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
